multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 opcode  input  6  inst[31:26] from datapath instruction register.
REQ-005 opr  input  6  inst[5:0] function field.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access complete this cycle (fetch and data).
REQ-008 selreg, regdst, alusrc, memread, memwrite, memtoreg, regwrite  output  1 each  datapath controls.
REQ-009 pcsrc, jal, jr, jmp  output  1 each  next-PC controls.
REQ-010 aluopration  output  3  ALU op: and=000, or=001, add=010, sub=110, slt=111.
REQ-011 pcwrite  output  1  PC load enable; irwrite  output  1  instruction register load enable.
REQ-012 illegal  output  1  one-cycle pulse on undecodable instruction.
REQ-013 instret  output  16  retired-instruction count.

Function
REQ-014 States SHALL be FETCH, DECODE, EXEC, MEM, WB; all outputs Moore-decoded from state plus opcode/opr/zero; every output not listed for a state is 0.
REQ-015 FETCH: memread=1; stay while mem_ready=0; when mem_ready=1, irwrite=1 and go to DECODE.
REQ-016 Legal decode: R-type opcode 000000 with opr add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000; addi 001000; slti 001010; lw 100011; sw 101011; beq 000100; j 000010; jal 000011.
REQ-017 DECODE, j: jmp=1, pcwrite=1 -> FETCH.
REQ-018 DECODE, jal: jmp=1, jal=1, selreg=1, regwrite=1, pcwrite=1 -> FETCH.
REQ-019 DECODE, jr: jmp=1, jr=1, aluopration=add, alusrc=0, pcwrite=1 -> FETCH.
REQ-020 DECODE, illegal opcode/opr: illegal=1, pcwrite=1 (sequential PC+4) -> FETCH.
REQ-021 DECODE, other legal instructions -> EXEC.
REQ-022 EXEC aluopration: R-type from opr; addi/lw/sw = add; slti = slt; beq = sub; alusrc=1 for addi, slti, lw, sw.
REQ-023 EXEC, beq: pcsrc=zero, pcwrite=1 -> FETCH (3 cycles min).
REQ-024 EXEC, lw/sw -> MEM; EXEC, R-type/addi/slti -> WB.
REQ-025 MEM: aluopration=add, alusrc=1 held; lw: memread=1; sw: memwrite=1; stay while mem_ready=0; on mem_ready=1: lw -> WB, sw -> pcwrite=1 and -> FETCH.
REQ-026 WB: regwrite=1, pcwrite=1 -> FETCH; regdst=1 for R-type, 0 for addi/slti/lw; memtoreg=1 for lw only; aluopration/alusrc held from EXEC.
REQ-027 memread and memwrite SHALL never be 1 together; regwrite and memwrite never 1 together.
REQ-028 instret SHALL increment by 1 on every clock edge where pcwrite=1 (including illegal), wrapping FFFF -> 0000.
REQ-029 Latencies with mem_ready held 1: j/jal/jr/illegal 2 cycles, beq 3, R-type/addi/slti/sw 4, lw 5; each mem_ready=0 cycle adds one.

Reset
REQ-030 rst=1 SHALL immediately force state FETCH, instret=0, and all outputs to their FETCH/reset values without waiting for clk; memwrite and regwrite SHALL be 0 during reset.
REQ-031 Reset asserted mid-MEM or mid-WB SHALL abort the instruction with no pcwrite, regwrite, or instret increment; after release, first rising edge evaluates FETCH.
REQ-032 FETCH during reset SHALL show memread=0, irwrite=0 until rst deasserts.

Verification
REQ-033 add (opcode 0, opr 100000), mem_ready=1 -> FETCH,DECODE,EXEC,WB; WB: regwrite=1, regdst=1, aluopration=010; instret 0->1.
REQ-034 lw with mem_ready low 2 cycles in MEM -> memread=1 for 3 MEM cycles, then WB memtoreg=1; total 7 cycles.
REQ-035 beq with zero=1 -> EXEC pcsrc=1, pcwrite=1, aluopration=110; zero=0 -> pcsrc=0, pcwrite=1.
REQ-036 jal -> DECODE: selreg=1, jal=1, jmp=1, regwrite=1, pcwrite=1; next cycle FETCH.
REQ-037 opcode 111111 -> illegal=1 for exactly one cycle, pcwrite=1, instret increments, back to FETCH.
REQ-038 sw in MEM, rst pulsed asynchronously between edges -> memwrite drops to 0 immediately, instret=0, state FETCH; 65536 retired instructions -> instret wraps to 0000.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// with datapath strobes decoded from state, opcode/opr and zero, plus a retired-instruction counter.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] opr,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       selreg,
    output logic       regdst,
    output logic       alusrc,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       pcsrc,
    output logic       jal,
    output logic       jr,
    output logic       jmp,
    output logic [2:0] aluopration,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       illegal,
    output logic [15:0] instret
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned CNT_W = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;
    localparam logic [OP_W-1:0] FN_JR  = 6'b001000;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic             is_rtype, is_jr, is_j, is_jal, is_beq, is_lw, is_sw, is_addi, is_slti;
    logic             r_legal, legal;
    logic [ALU_W-1:0] r_alu, exec_alu;
    logic             exec_alusrc;

    // Instruction classification from the held instruction register fields
    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        is_addi  = (opcode == OP_ADDI);
        is_slti  = (opcode == OP_SLTI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_j     = (opcode == OP_J);
        is_jal   = (opcode == OP_JAL);
        is_jr    = is_rtype && (opr == FN_JR);

        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case (opr)
            FN_ADD:  r_alu = ALU_ADD;
            FN_SUB:  r_alu = ALU_SUB;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_SLT:  r_alu = ALU_SLT;
            FN_JR:   r_alu = ALU_ADD;
            default: r_legal = 1'b0;
        endcase

        legal = (is_rtype && r_legal) || is_addi || is_slti || is_lw || is_sw
              || is_beq || is_j || is_jal;

        if (is_rtype) begin
            exec_alu = r_alu;
        end else if (is_slti) begin
            exec_alu = ALU_SLT;
        end else if (is_beq) begin
            exec_alu = ALU_SUB;
        end else begin
            exec_alu = ALU_ADD;
        end
        exec_alusrc = is_addi || is_slti || is_lw || is_sw;
    end

    // Next state and control strobes; everything is held low while rst is asserted
    always_comb begin
        state_d     = state_q;
        selreg      = 1'b0;
        regdst      = 1'b0;
        alusrc      = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        pcsrc       = 1'b0;
        jal         = 1'b0;
        jr          = 1'b0;
        jmp         = 1'b0;
        aluopration = ALU_AND;
        pcwrite     = 1'b0;
        irwrite     = 1'b0;
        illegal     = 1'b0;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        illegal = 1'b1;
                        pcwrite = 1'b1;
                        state_d = S_FETCH;
                    end else if (is_j) begin
                        jmp     = 1'b1;
                        pcwrite = 1'b1;
                        state_d = S_FETCH;
                    end else if (is_jal) begin
                        jmp      = 1'b1;
                        jal      = 1'b1;
                        selreg   = 1'b1;
                        regwrite = 1'b1;
                        pcwrite  = 1'b1;
                        state_d  = S_FETCH;
                    end else if (is_jr) begin
                        jmp         = 1'b1;
                        jr          = 1'b1;
                        aluopration = ALU_ADD;
                        pcwrite     = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    aluopration = exec_alu;
                    alusrc      = exec_alusrc;
                    if (is_beq) begin
                        pcsrc   = zero;
                        pcwrite = 1'b1;
                        state_d = S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_MEM: begin
                    aluopration = ALU_ADD;
                    alusrc      = 1'b1;
                    memread     = is_lw;
                    memwrite    = is_sw;
                    if (mem_ready) begin
                        if (is_lw) begin
                            state_d = S_WB;
                        end else begin
                            pcwrite = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    aluopration = exec_alu;
                    alusrc      = exec_alusrc;
                    regwrite    = 1'b1;
                    pcwrite     = 1'b1;
                    regdst      = is_rtype;
                    memtoreg    = is_lw;
                    state_d     = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // Each PC update retires one instruction, illegal ones included
    always_comb begin
        instret_d = instret_q + CNT_W'(pcwrite);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: per-cycle strobe vectors
// and retired-instruction count against hand-computed expectations.
module tb_multicycle_controller;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  opr;
    logic        zero;
    logic        mem_ready;
    logic        selreg, regdst, alusrc, memread, memwrite, memtoreg, regwrite;
    logic        pcsrc, jal, jr, jmp, pcwrite, irwrite, illegal;
    logic [2:0]  aluopration;
    logic [15:0] instret;
    logic [16:0] ctl;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_ret = '0;

    localparam logic [16:0] SELREG = 17'h00008;
    localparam logic [16:0] REGDST = 17'h00010;
    localparam logic [16:0] ALUSRC = 17'h00020;
    localparam logic [16:0] MEMRD  = 17'h00040;
    localparam logic [16:0] MEMWR  = 17'h00080;
    localparam logic [16:0] M2R    = 17'h00100;
    localparam logic [16:0] REGWR  = 17'h00200;
    localparam logic [16:0] PCSRC  = 17'h00400;
    localparam logic [16:0] JAL    = 17'h00800;
    localparam logic [16:0] JR     = 17'h01000;
    localparam logic [16:0] JMP    = 17'h02000;
    localparam logic [16:0] PCWR   = 17'h04000;
    localparam logic [16:0] IRWR   = 17'h08000;
    localparam logic [16:0] ILL    = 17'h10000;
    localparam logic [16:0] A_AND  = 17'h00000;
    localparam logic [16:0] A_OR   = 17'h00001;
    localparam logic [16:0] A_ADD  = 17'h00002;
    localparam logic [16:0] A_SUB  = 17'h00006;
    localparam logic [16:0] A_SLT  = 17'h00007;
    localparam logic [16:0] FETCH_GO = MEMRD | IRWR;

    multicycle_controller dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .opr         (opr),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .selreg      (selreg),
        .regdst      (regdst),
        .alusrc      (alusrc),
        .memread     (memread),
        .memwrite    (memwrite),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .pcsrc       (pcsrc),
        .jal         (jal),
        .jr          (jr),
        .jmp         (jmp),
        .aluopration (aluopration),
        .pcwrite     (pcwrite),
        .irwrite     (irwrite),
        .illegal     (illegal),
        .instret     (instret)
    );

    assign ctl = {illegal, irwrite, pcwrite, jmp, jr, jal, pcsrc, regwrite,
                  memtoreg, memwrite, memread, alusrc, regdst, selreg, aluopration};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check one cycle's strobes and count, then advance past the next rising edge
    task automatic step(input string tag, input logic [16:0] exp);
        #1;
        check({tag, ".ctl"}, 32'(ctl), 32'(exp));
        check({tag, ".ret"}, 32'(instret), 32'(exp_ret));
        @(posedge clk);
        if ((exp & PCWR) != 17'h0) exp_ret = exp_ret + 16'd1;
        #2;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'b0; opr = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        #3;
        check("reset.ctl", 32'(ctl), 32'h0);
        check("reset.ret", 32'(instret), 32'h0);
        @(posedge clk); #2;
        mem_ready = 1'b1;
        #1;
        check("reset.fetch_quiet", 32'(ctl), 32'h0);
        #1;
        rst = 1'b0;

        // add: 4 cycles, instret 0 -> 1
        opcode = 6'b000000; opr = 6'b100000;
        step("add.F", FETCH_GO);
        step("add.D", 17'h0);
        step("add.E", A_ADD);
        step("add.WB", REGWR | PCWR | REGDST | A_ADD);

        // fetch stall, then lw with two MEM wait cycles
        opcode = 6'b100011; mem_ready = 1'b0;
        step("stall.F", MEMRD);
        mem_ready = 1'b1;
        step("lw.F", FETCH_GO);
        step("lw.D", 17'h0);
        step("lw.E", ALUSRC | A_ADD);
        mem_ready = 1'b0;
        step("lw.M0", MEMRD | ALUSRC | A_ADD);
        step("lw.M1", MEMRD | ALUSRC | A_ADD);
        mem_ready = 1'b1;
        step("lw.M2", MEMRD | ALUSRC | A_ADD);
        step("lw.WB", REGWR | PCWR | M2R | ALUSRC | A_ADD);

        // beq taken and not taken
        opcode = 6'b000100; zero = 1'b1;
        step("beq1.F", FETCH_GO);
        step("beq1.D", 17'h0);
        step("beq1.E", PCSRC | PCWR | A_SUB);
        zero = 1'b0;
        step("beq0.F", FETCH_GO);
        step("beq0.D", 17'h0);
        step("beq0.E", PCWR | A_SUB);

        // jal, then an undecodable opcode
        opcode = 6'b000011;
        step("jal.F", FETCH_GO);
        step("jal.D", SELREG | JAL | JMP | REGWR | PCWR);
        opcode = 6'b111111;
        step("ill.F", FETCH_GO);
        step("ill.D", ILL | PCWR);
        opcode = 6'b000010;
        step("j.F", FETCH_GO);
        step("j.D", JMP | PCWR);

        // jr, slti, bad R-type function, or, addi
        opcode = 6'b000000; opr = 6'b001000;
        step("jr.F", FETCH_GO);
        step("jr.D", JMP | JR | PCWR | A_ADD);
        opcode = 6'b001010;
        step("slti.F", FETCH_GO);
        step("slti.D", 17'h0);
        step("slti.E", ALUSRC | A_SLT);
        step("slti.WB", REGWR | PCWR | ALUSRC | A_SLT);
        opcode = 6'b000000; opr = 6'b111111;
        step("badfn.F", FETCH_GO);
        step("badfn.D", ILL | PCWR);
        opr = 6'b100101;
        step("or.F", FETCH_GO);
        step("or.D", 17'h0);
        step("or.E", A_OR);
        step("or.WB", REGWR | PCWR | REGDST | A_OR);
        opcode = 6'b001000;
        step("addi.F", FETCH_GO);
        step("addi.D", 17'h0);
        step("addi.E", ALUSRC | A_ADD);
        step("addi.WB", REGWR | PCWR | ALUSRC | A_ADD);
        opcode = 6'b000000; opr = 6'b100100;
        step("and.F", FETCH_GO);
        step("and.D", 17'h0);
        step("and.E", A_AND);
        step("and.WB", REGWR | PCWR | REGDST | A_AND);

        // sw aborted by an asynchronous reset in MEM
        opcode = 6'b101011;
        step("sw.F", FETCH_GO);
        step("sw.D", 17'h0);
        step("sw.E", ALUSRC | A_ADD);
        mem_ready = 1'b0;
        step("sw.M0", MEMWR | ALUSRC | A_ADD);
        #1;
        check("swrst.pre", 32'(ctl), 32'(MEMWR | ALUSRC | A_ADD));
        rst = 1'b1;
        #1;
        check("swrst.ctl", 32'(ctl), 32'h0);
        check("swrst.ret", 32'(instret), 32'h0);
        exp_ret = '0;
        @(posedge clk); #2;
        rst = 1'b0; mem_ready = 1'b1;
        step("swrst.F", FETCH_GO);
        step("sw2.D", 17'h0);
        step("sw2.E", ALUSRC | A_ADD);
        step("sw2.M", MEMWR | ALUSRC | A_ADD | PCWR);

        // instret wrap: preload near the top, then retire two jumps
        force dut.instret_q = 16'hFFFE;
        #1;
        release dut.instret_q;
        exp_ret = 16'hFFFE;
        opcode = 6'b000010;
        step("wrap0.F", FETCH_GO);
        step("wrap0.D", JMP | PCWR);
        step("wrap1.F", FETCH_GO);
        step("wrap1.D", JMP | PCWR);
        #1;
        check("wrap.ret", 32'(instret), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
